// File: rtl/businterface_multicycle_pkg.sv
// Shared types and constants for the clocked CPU-to-bus byte-lane interface.
package businterface_multicycle_pkg;

  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_WORD = 2'd1,
    CW_LONG = 2'd2,
    CW_NULL = 2'd3
  } cycle_width_t;

  typedef enum logic [2:0] {
    BI_IDLE,
    BI_FIRST,
    BI_SECOND,
    BI_DONE,
    BI_ERROR
  } bi_state_t;

  localparam logic [7:0]  LANE_FILL = 8'hff;
  localparam logic [31:0] BUS_FILL  = {4{LANE_FILL}};

  function automatic logic [2:0] width_bytes(input logic [1:0] cw);
    case (cw)
      CW_BYTE: return 3'd1;
      CW_WORD: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Word at an odd offset, or long anywhere but offset 0.
  function automatic logic is_unaligned(input logic [1:0] cw, input logic [1:0] offset);
    case (cw)
      CW_WORD: return offset[0];
      CW_LONG: return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/businterface_multicycle_lanes.sv
// Combinational lane mapper: strobes and write lanes for one half of an access,
// the split flag, and the shifts that right-justify assembled read data.
module businterface_multicycle_lanes
  import businterface_multicycle_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  nbytes,
  input  logic        second,
  input  logic [31:0] wdata,
  output logic [3:0]  strobes,
  output logic [31:0] lane_data,
  output logic        split,
  output logic [5:0]  rd_lshift,
  output logic [5:0]  rd_rshift
);

  logic [3:0]  size_mask;
  logic [7:0]  mask8;
  logic [31:0] left;
  logic [63:0] data64;
  logic [31:0] part_data;

  // The access is placed in an 8-lane window: upper four lanes are the first
  // longword, lower four the following one.
  always_comb begin
    case (nbytes)
      3'd1:    size_mask = 4'b1000;
      3'd2:    size_mask = 4'b1100;
      default: size_mask = 4'b1111;
    endcase
    mask8     = {size_mask, 4'b0000} >> offset;
    split     = |mask8[3:0];
    rd_lshift = {1'b0, offset, 3'b000};
    rd_rshift = {3'd4 - nbytes, 3'b000};
    left      = wdata << rd_rshift;
    data64    = {left, BUS_FILL} >> rd_lshift;
    strobes   = second ? mask8[3:0]   : mask8[7:4];
    part_data = second ? data64[31:0] : data64[63:32];
    lane_data = BUS_FILL;
    for (int k = 0; k < 4; k++) begin
      if (strobes[3-k]) lane_data[31-8*k -: 8] = part_data[31-8*k -: 8];
    end
  end

endmodule

// File: rtl/businterface_multicycle.sv
// Clocked CPU-to-bus interface: maps byte/word/long accesses onto a big-endian
// 32-bit longword bus, splitting boundary-crossing accesses into two transfers.
module businterface_multicycle
  import businterface_multicycle_pkg::*;
#(
  parameter bit ALLOW_UNALIGNED = 1'b1,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TIMEOUT_WIDTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  cpu_cycle_width,
  input  logic [31:0] cpu_data_out,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_data_in,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_bus_error,
  output logic [29:0] businterface_address,
  input  logic [31:0] businterface_data_in,
  output logic [31:0] businterface_data_out,
  output logic [3:0]  businterface_data_strobes,
  output logic        businterface_read,
  output logic        businterface_write,
  input  logic        businterface_ack
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  bi_state_t              state, state_d;
  logic [31:0]            req_addr, req_addr_d;
  logic [1:0]             req_width, req_width_d;
  logic                   req_write, req_write_d;
  logic [31:0]            req_wdata, req_wdata_d;
  logic [TIMEOUT_WIDTH-1:0] timer, timer_d;
  logic [31:0]            asm_hi, asm_hi_d;

  logic [31:0] cpu_data_in_d, bus_dout_d;
  logic [29:0] bus_addr_d;
  logic [3:0]  bus_strb_d;
  logic        busy_d, done_d, err_d, bus_rd_d, bus_wr_d;

  logic [1:0]  ln_offset;
  logic [2:0]  ln_nbytes;
  logic [31:0] ln_wdata, ln_data;
  logic [3:0]  ln_strobes;
  logic        ln_second, ln_split;
  logic [5:0]  rd_lshift, rd_rshift;

  logic        accept, illegal, timed_out;
  logic [63:0] rd_window, rd_aligned;
  logic [31:0] rd_value;

  // In IDLE the mapper sees the live request; afterwards the latched one.
  assign ln_offset = (state == BI_IDLE) ? cpu_address[1:0] : req_addr[1:0];
  assign ln_nbytes = width_bytes((state == BI_IDLE) ? cpu_cycle_width : req_width);
  assign ln_wdata  = (state == BI_IDLE) ? cpu_data_out : req_wdata;
  assign ln_second = (state != BI_IDLE);

  businterface_multicycle_lanes u_lanes (
    .offset    (ln_offset),
    .nbytes    (ln_nbytes),
    .second    (ln_second),
    .wdata     (ln_wdata),
    .strobes   (ln_strobes),
    .lane_data (ln_data),
    .split     (ln_split),
    .rd_lshift (rd_lshift),
    .rd_rshift (rd_rshift)
  );

  assign accept  = cpu_read | cpu_write;
  assign illegal = (cpu_read & cpu_write) || (cpu_cycle_width == CW_NULL) ||
                   (!ALLOW_UNALIGNED && is_unaligned(cpu_cycle_width, cpu_address[1:0]));
  assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_LAST);

  // First-transfer bytes are most significant in the assembled window.
  assign rd_window  = (state == BI_SECOND) ? {asm_hi, businterface_data_in}
                                           : {businterface_data_in, BUS_FILL};
  assign rd_aligned = rd_window << rd_lshift;
  assign rd_value   = (rd_aligned[63:32] >> rd_rshift) | ~(BUS_FILL >> rd_rshift);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state;
    req_addr_d    = req_addr;
    req_width_d   = req_width;
    req_write_d   = req_write;
    req_wdata_d   = req_wdata;
    timer_d       = timer;
    asm_hi_d      = asm_hi;
    bus_addr_d    = businterface_address;
    bus_strb_d    = businterface_data_strobes;
    bus_dout_d    = businterface_data_out;
    bus_rd_d      = businterface_read;
    bus_wr_d      = businterface_write;
    busy_d        = cpu_busy;
    done_d        = 1'b0;
    err_d         = 1'b0;
    cpu_data_in_d = BUS_FILL;

    case (state)
      BI_IDLE: begin
        if (accept) begin
          req_addr_d  = cpu_address;
          req_width_d = cpu_cycle_width;
          req_write_d = cpu_write;
          req_wdata_d = cpu_data_out;
          if (illegal) begin
            state_d = BI_ERROR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = BI_FIRST;
            busy_d     = 1'b1;
            timer_d    = '0;
            bus_addr_d = cpu_address[31:2];
            bus_strb_d = ln_strobes;
            bus_dout_d = ln_data;
            bus_rd_d   = cpu_read;
            bus_wr_d   = cpu_write;
          end
        end
      end

      BI_FIRST, BI_SECOND: begin
        if (businterface_ack) begin
          asm_hi_d   = businterface_data_in;
          bus_strb_d = 4'b0000;
          bus_dout_d = BUS_FILL;
          bus_rd_d   = 1'b0;
          bus_wr_d   = 1'b0;
          if (state == BI_FIRST && ln_split) begin
            state_d    = BI_SECOND;
            timer_d    = '0;
            bus_addr_d = req_addr[31:2] + 30'd1;
            bus_strb_d = ln_strobes;
            bus_dout_d = ln_data;
            bus_rd_d   = !req_write;
            bus_wr_d   = req_write;
          end else begin
            state_d       = BI_DONE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            cpu_data_in_d = req_write ? BUS_FILL : rd_value;
          end
        end else if (timed_out) begin
          // A completed first half of a split write stays written.
          state_d    = BI_ERROR;
          timer_d    = timer + TIMEOUT_WIDTH'(1);
          bus_strb_d = 4'b0000;
          bus_dout_d = BUS_FILL;
          bus_rd_d   = 1'b0;
          bus_wr_d   = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          err_d      = 1'b1;
        end else begin
          timer_d = timer + TIMEOUT_WIDTH'(1);
        end
      end

      BI_DONE, BI_ERROR: state_d = BI_IDLE;

      default: state_d = BI_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                     <= BI_IDLE;
      req_addr                  <= '0;
      req_width                 <= CW_NULL;
      req_write                 <= 1'b0;
      req_wdata                 <= '0;
      timer                     <= '0;
      asm_hi                    <= BUS_FILL;
      cpu_data_in               <= BUS_FILL;
      cpu_busy                  <= 1'b0;
      cpu_done                  <= 1'b0;
      cpu_bus_error             <= 1'b0;
      businterface_address      <= '0;
      businterface_data_out     <= BUS_FILL;
      businterface_data_strobes <= 4'b0000;
      businterface_read         <= 1'b0;
      businterface_write        <= 1'b0;
    end else begin
      state                     <= state_d;
      req_addr                  <= req_addr_d;
      req_width                 <= req_width_d;
      req_write                 <= req_write_d;
      req_wdata                 <= req_wdata_d;
      timer                     <= timer_d;
      asm_hi                    <= asm_hi_d;
      cpu_data_in               <= cpu_data_in_d;
      cpu_busy                  <= busy_d;
      cpu_done                  <= done_d;
      cpu_bus_error             <= err_d;
      businterface_address      <= bus_addr_d;
      businterface_data_out     <= bus_dout_d;
      businterface_data_strobes <= bus_strb_d;
      businterface_read         <= bus_rd_d;
      businterface_write        <= bus_wr_d;
    end
  end

endmodule

// File: tb/tb_businterface_multicycle.sv
// Directed bench: a permissive instance (timeout 4) and a strict instance
// (unaligned accesses rejected) driven by a simple bus responder.
module tb_businterface_multicycle;
  import businterface_multicycle_pkg::*;

  localparam int MAX_CYC = 50;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_address, cpu_data_out, bus_din;
  logic [1:0]  cpu_cycle_width;
  logic        cpu_read, cpu_write, s_read, s_write, bus_ack;

  logic [31:0] m_din, m_dout, s_din, s_dout;
  logic        m_busy, m_done, m_err, m_rd, m_wr;
  logic        s_busy, s_done, s_err, s_rd, s_wr;
  logic [29:0] m_addr, s_addr;
  logic [3:0]  m_strb, s_strb;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent access.
  int          tr_n, strobed, lat;
  logic [29:0] tr_addr [2];
  logic [3:0]  tr_strb [2];
  logic [31:0] tr_dout [2];
  logic        tr_rd, tr_wr, tr_busy;
  logic        got_done, got_err;
  logic [31:0] got_data;
  logic [3:0]  done_strb;

  always #5 clock = ~clock;

  businterface_multicycle #(.ALLOW_UNALIGNED(1'b1), .TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_cycle_width(cpu_cycle_width), .cpu_data_out(cpu_data_out),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_data_in(m_din), .cpu_busy(m_busy), .cpu_done(m_done), .cpu_bus_error(m_err),
    .businterface_address(m_addr), .businterface_data_in(bus_din),
    .businterface_data_out(m_dout), .businterface_data_strobes(m_strb),
    .businterface_read(m_rd), .businterface_write(m_wr), .businterface_ack(bus_ack)
  );

  businterface_multicycle #(.ALLOW_UNALIGNED(1'b0), .TIMEOUT_CYCLES(255), .TIMEOUT_WIDTH(8)) dut_strict (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_cycle_width(cpu_cycle_width), .cpu_data_out(cpu_data_out),
    .cpu_read(s_read), .cpu_write(s_write),
    .cpu_data_in(s_din), .cpu_busy(s_busy), .cpu_done(s_done), .cpu_bus_error(s_err),
    .businterface_address(s_addr), .businterface_data_in(bus_din),
    .businterface_data_out(s_dout), .businterface_data_strobes(s_strb),
    .businterface_read(s_rd), .businterface_write(s_wr), .businterface_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Presents one request, answers each bus transfer after waitsN cycles with
  // rdataN, and records what the interface did until cpu_done.
  task automatic run_access(input bit strict, input logic rd, input logic wr,
                            input logic [1:0] cw, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata0,
                            input logic [31:0] rdata1, input int waits0, input int waits1);
    int   waited;
    bit   in_tr;
    logic o_done, o_err, o_busy, o_rd, o_wr;
    logic [3:0]  o_strb;
    logic [29:0] o_addr;
    logic [31:0] o_din, o_dout;
    @(negedge clock);
    cpu_address = addr; cpu_cycle_width = cw; cpu_data_out = wdata;
    if (strict) begin s_read = rd; s_write = wr; end
    else begin cpu_read = rd; cpu_write = wr; end
    tr_n = 0; strobed = 0; lat = 0; got_done = 1'b0; got_err = 1'b0;
    got_data = 32'h0; done_strb = 4'hx; waited = 0; in_tr = 1'b0; bus_ack = 1'b0;
    tr_rd = 1'b0; tr_wr = 1'b0; tr_busy = 1'b0;
    for (int c = 1; c <= MAX_CYC && !got_done; c++) begin
      @(negedge clock);
      if (strict) begin
        o_done = s_done; o_err = s_err; o_busy = s_busy; o_rd = s_rd; o_wr = s_wr;
        o_strb = s_strb; o_addr = s_addr; o_din = s_din; o_dout = s_dout;
      end else begin
        o_done = m_done; o_err = m_err; o_busy = m_busy; o_rd = m_rd; o_wr = m_wr;
        o_strb = m_strb; o_addr = m_addr; o_din = m_din; o_dout = m_dout;
      end
      bus_ack = 1'b0;
      if (o_done) begin
        got_done = 1'b1; lat = c; got_err = o_err; got_data = o_din; done_strb = o_strb;
      end else if (o_strb != 4'b0000) begin
        strobed++;
        if (!in_tr) begin
          if (tr_n < 2) begin
            tr_addr[tr_n] = o_addr; tr_strb[tr_n] = o_strb; tr_dout[tr_n] = o_dout;
          end
          if (tr_n == 0) begin tr_rd = o_rd; tr_wr = o_wr; tr_busy = o_busy; end
          tr_n++;
          in_tr  = 1'b1;
          waited = 0;
        end
        if (waited == ((tr_n == 1) ? waits0 : waits1)) begin
          bus_ack = 1'b1;
          bus_din = (tr_n == 1) ? rdata0 : rdata1;
          in_tr   = 1'b0;
        end else begin
          waited++;
        end
      end
    end
    cpu_read = 1'b0; cpu_write = 1'b0; s_read = 1'b0; s_write = 1'b0; bus_ack = 1'b0;
    check("done_seen", {31'b0, got_done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset = 1'b1;
    cpu_address = '0; cpu_cycle_width = CW_NULL; cpu_data_out = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; s_read = 1'b0; s_write = 1'b0;
    bus_ack = 1'b0; bus_din = '0;
    repeat (2) @(negedge clock);
    check("rst_strb",  {28'b0, m_strb}, 32'h0);
    check("rst_rdwr",  {30'b0, m_rd, m_wr}, 32'h0);
    check("rst_busy",  {31'b0, m_busy}, 32'h0);
    check("rst_done",  {30'b0, m_done, m_err}, 32'h0);
    check("rst_addr",  {2'b0, m_addr}, 32'h0);
    check("rst_dout",  m_dout, 32'hffffffff);
    check("rst_din",   m_din, 32'hffffffff);
    reset = 1'b0;

    // Aligned long read, zero-wait: done in the third cycle counting the request cycle.
    run_access(1'b0, 1'b1, 1'b0, CW_LONG, 32'h0000_0100, 32'h0, 32'h1122_3344, 32'h0, 0, 0);
    check("lr_ntr",  tr_n, 32'd1);
    check("lr_addr", {2'b0, tr_addr[0]}, 32'h40);
    check("lr_strb", {28'b0, tr_strb[0]}, 32'hf);
    check("lr_rdwr", {30'b0, tr_rd, tr_wr}, 32'h2);
    check("lr_busy", {31'b0, tr_busy}, 32'h1);
    check("lr_data", got_data, 32'h1122_3344);
    check("lr_err",  {31'b0, got_err}, 32'h0);
    check("lr_lat",  lat, 32'd2);
    check("lr_strb_off", {28'b0, done_strb}, 32'h0);

    // Byte write at offset 3.
    run_access(1'b0, 1'b0, 1'b1, CW_BYTE, 32'h0000_0203, 32'h0000_00ab, 32'h0, 32'h0, 0, 0);
    check("bw_ntr",  tr_n, 32'd1);
    check("bw_addr", {2'b0, tr_addr[0]}, 32'h80);
    check("bw_strb", {28'b0, tr_strb[0]}, 32'h1);
    check("bw_dout", tr_dout[0], 32'hffff_ffab);
    check("bw_rdwr", {30'b0, tr_rd, tr_wr}, 32'h1);
    check("bw_err",  {31'b0, got_err}, 32'h0);

    // Split long read, second transfer waits 2 cycles.
    run_access(1'b0, 1'b1, 1'b0, CW_LONG, 32'h0000_0101, 32'h0, 32'h0011_2233, 32'h4455_6677, 0, 2);
    check("sr_ntr",   tr_n, 32'd2);
    check("sr_addr0", {2'b0, tr_addr[0]}, 32'h40);
    check("sr_strb0", {28'b0, tr_strb[0]}, 32'h7);
    check("sr_addr1", {2'b0, tr_addr[1]}, 32'h41);
    check("sr_strb1", {28'b0, tr_strb[1]}, 32'h8);
    check("sr_data",  got_data, 32'h1122_3344);
    check("sr_lat",   lat, 32'd5);

    // Split word write wrapping the longword address.
    run_access(1'b0, 1'b0, 1'b1, CW_WORD, 32'hffff_ffff, 32'h0000_beef, 32'h0, 32'h0, 0, 0);
    check("ww_ntr",   tr_n, 32'd2);
    check("ww_addr0", {2'b0, tr_addr[0]}, 32'h3fff_ffff);
    check("ww_strb0", {28'b0, tr_strb[0]}, 32'h1);
    check("ww_dout0", tr_dout[0], 32'hffff_ffbe);
    check("ww_addr1", {2'b0, tr_addr[1]}, 32'h0);
    check("ww_strb1", {28'b0, tr_strb[1]}, 32'h8);
    check("ww_dout1", tr_dout[1], 32'hefff_ffff);
    check("ww_lat",   lat, 32'd3);

    // Unaligned word inside one longword.
    run_access(1'b0, 1'b1, 1'b0, CW_WORD, 32'h0000_0101, 32'h0, 32'haa12_34bb, 32'h0, 0, 0);
    check("uw_ntr",  tr_n, 32'd1);
    check("uw_strb", {28'b0, tr_strb[0]}, 32'h6);
    check("uw_data", got_data, 32'hffff_1234);

    // Illegal requests.
    run_access(1'b0, 1'b1, 1'b0, CW_NULL, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0, 0);
    check("null_ntr",  tr_n, 32'd0);
    check("null_err",  {31'b0, got_err}, 32'h1);
    check("null_data", got_data, 32'hffff_ffff);
    check("null_lat",  lat, 32'd1);
    run_access(1'b0, 1'b1, 1'b1, CW_LONG, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0, 0);
    check("rw_ntr", tr_n, 32'd0);
    check("rw_err", {31'b0, got_err}, 32'h1);
    run_access(1'b1, 1'b1, 1'b0, CW_WORD, 32'h0000_0003, 32'h0, 32'h0, 32'h0, 0, 0);
    check("st_w3_ntr", tr_n, 32'd0);
    check("st_w3_err", {31'b0, got_err}, 32'h1);
    run_access(1'b1, 1'b0, 1'b1, CW_LONG, 32'h0000_0002, 32'h0, 32'h0, 32'h0, 0, 0);
    check("st_l2_ntr", tr_n, 32'd0);
    check("st_l2_err", {31'b0, got_err}, 32'h1);
    run_access(1'b1, 1'b1, 1'b0, CW_WORD, 32'h0000_0002, 32'h0, 32'h0000_cafe, 32'h0, 0, 0);
    check("st_w2_ntr",  tr_n, 32'd1);
    check("st_w2_strb", {28'b0, tr_strb[0]}, 32'h3);
    check("st_w2_data", got_data, 32'hffff_cafe);
    check("st_w2_err",  {31'b0, got_err}, 32'h0);

    // Ack never arrives: four strobed cycles, then a bus error.
    run_access(1'b0, 1'b1, 1'b0, CW_LONG, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 1000, 1000);
    check("to_ntr",     tr_n, 32'd1);
    check("to_strobed", strobed, 32'd4);
    check("to_err",     {31'b0, got_err}, 32'h1);
    check("to_data",    got_data, 32'hffff_ffff);
    check("to_strb",    {28'b0, done_strb}, 32'h0);

    // Reset in FIRST: strobes drop at the next edge and no completion follows.
    @(negedge clock);
    cpu_address = 32'h0000_0300; cpu_cycle_width = CW_LONG; cpu_read = 1'b1;
    @(negedge clock);
    check("rm_strb_pre", {28'b0, m_strb}, 32'hf);
    reset = 1'b1; cpu_read = 1'b0;
    @(negedge clock);
    check("rm_strb", {28'b0, m_strb}, 32'h0);
    check("rm_rd",   {31'b0, m_rd}, 32'h0);
    check("rm_busy", {31'b0, m_busy}, 32'h0);
    reset = 1'b0;
    bus_ack = 1'b1;   // acks while idle are ignored
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (m_done) saw_done = 1'b1;
    end
    bus_ack = 1'b0;
    check("rm_no_done", {31'b0, saw_done}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
